// File: rtl/kpack_pkg.sv
// Shared definitions for the kernel packer: default geometry, the bit-width
// helper and the coefficient/column types used across the design and bench.
package kpack_pkg;

  localparam int DEF_K_DIM  = 3;
  localparam int DEF_M_BITS = 16;
  localparam int K_SIZE     = DEF_K_DIM * DEF_K_DIM;

  // Number of bits needed to encode n distinct values (at least one bit).
  function automatic int nbits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [DEF_M_BITS-1:0] coef_t;
  typedef coef_t [DEF_K_DIM-1:0] column_t;

endpackage

// File: rtl/kpack_bank.sv
// One kernel buffer of K_DIM*K_DIM coefficients with its full flag, fill count
// and a column read mux. Entries at or beyond the fill count read as zero, so a
// short kernel is padded without clearing the storage.
// Build option: KPACK_TRANSPOSE_EN selects row-major-to-column transposition;
// when undefined each column beat is a contiguous chunk of the input order.
module kpack_bank
  import kpack_pkg::*;
#(
  parameter  int K_DIM  = DEF_K_DIM,
  parameter  int M_BITS = DEF_M_BITS,
  localparam int N_ELEM = K_DIM * K_DIM,
  localparam int CW     = nbits(N_ELEM + 1),
  localparam int COLW   = nbits(K_DIM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  logic [CW-1:0]                 i_wr_idx,
  input  logic [M_BITS-1:0]             i_wr_data,
  input  logic                          i_close,
  input  logic [CW-1:0]                 i_close_cnt,
  input  logic                          i_free,
  input  logic [COLW-1:0]               i_col,
  output logic                          o_full,
  output logic [K_DIM-1:0][M_BITS-1:0]  o_col_data
);

  logic [M_BITS-1:0] r_mem [N_ELEM];
  logic              r_full;
  logic [CW-1:0]     r_fcnt;

  // Source element for output lane j of column c.
  function automatic int elemIdx(input int j, input int c);
`ifdef KPACK_TRANSPOSE_EN
    return j * K_DIM + c;
`else
    return c * K_DIM + j;
`endif
  endfunction

  // Coefficient storage; contents need no reset because fcnt masks them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Full flag and fill count: set when the writer closes, cleared on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_fcnt <= '0;
    end else if (i_close) begin
      r_full <= 1'b1;
      r_fcnt <= i_close_cnt;
    end else if (i_free) begin
      r_full <= 1'b0;
    end
  end

  // Column mux, zero-filling entries that were never written in this kernel.
  always_comb begin
    o_col_data = '0;
    for (int j = 0; j < K_DIM; j++) begin
      int idx;
      idx = elemIdx(j, int'(i_col));
      if (idx < int'(r_fcnt)) begin
        o_col_data[j] = r_mem[idx[CW-1:0]];
      end
    end
  end

  assign o_full = r_full;

endmodule

// File: rtl/kernel_packer.sv
// Kernel packer top: collects a scalar coefficient stream into ping-pong
// kernel banks and replays each kernel as K_DIM column beats. Malformed
// kernel lengths close the bank anyway and raise a one-cycle err_len pulse.
// Build option: KPACK_TRANSPOSE_EN (see kpack_bank) picks the column order.
module kernel_packer
  import kpack_pkg::*;
#(
  parameter int K_DIM  = DEF_K_DIM,
  parameter int M_BITS = DEF_M_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [M_BITS-1:0]             s_data,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [K_DIM-1:0][M_BITS-1:0]  k_out_data,
  output logic                          k_out_last,
  output logic                          k_out_valid,
  input  logic                          k_out_ready,
  output logic                          err_len
);

  localparam int N_ELEM = K_DIM * K_DIM;
  localparam int CW     = nbits(N_ELEM + 1);
  localparam int COLW   = nbits(K_DIM);

  logic                          r_wr_sel;
  logic                          r_rd_sel;
  logic [CW-1:0]                 r_wcnt;
  logic [COLW-1:0]               r_col;
  logic                          r_ready;
  logic                          r_err;

  logic                          w_accept;
  logic                          w_at_end;
  logic                          w_close;
  logic                          w_err;
  logic                          w_out_valid;
  logic                          w_handshake;
  logic                          w_last_col;
  logic                          w_free;
  logic                          w_wr_sel_next;
  logic [1:0]                    w_full;
  logic [1:0]                    w_full_next;
  logic [K_DIM-1:0][M_BITS-1:0]  w_col_data [2];

  assign w_accept      = s_valid & r_ready;
  assign w_at_end      = (r_wcnt == CW'(N_ELEM - 1));
  assign w_close       = w_accept & (s_last | w_at_end);
  assign w_err         = w_accept & (s_last ^ w_at_end);
  assign w_out_valid   = w_full[r_rd_sel];
  assign w_handshake   = w_out_valid & k_out_ready;
  assign w_last_col    = (r_col == COLW'(K_DIM - 1));
  assign w_free        = w_handshake & w_last_col;
  assign w_wr_sel_next = r_wr_sel ^ w_close;

  // Next-cycle full flags: closing and draining never hit the same bank.
  always_comb begin
    w_full_next = '0;
    for (int b = 0; b < 2; b++) begin
      w_full_next[b] = (w_full[b] & ~(w_free & (r_rd_sel == 1'(b))))
                     | (w_close & (r_wr_sel == 1'(b)));
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    kpack_bank #(
      .K_DIM  (K_DIM),
      .M_BITS (M_BITS)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .i_wr_en     (w_accept & (r_wr_sel == 1'(b))),
      .i_wr_idx    (r_wcnt),
      .i_wr_data   (s_data),
      .i_close     (w_close & (r_wr_sel == 1'(b))),
      .i_close_cnt (r_wcnt + CW'(1)),
      .i_free      (w_free & (r_rd_sel == 1'(b))),
      .i_col       (r_col),
      .o_full      (w_full[b]),
      .o_col_data  (w_col_data[b])
    );
  end

  // Write pointer, element counter, registered ready and length-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel <= 1'b0;
      r_wcnt   <= '0;
      r_ready  <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_err   <= w_err;
      r_ready <= ~w_full_next[w_wr_sel_next];
      if (w_close) begin
        r_wr_sel <= ~r_wr_sel;
        r_wcnt   <= '0;
      end else if (w_accept) begin
        r_wcnt <= r_wcnt + CW'(1);
      end
    end
  end

  // Read pointer and column counter advance on each output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sel <= 1'b0;
      r_col    <= '0;
    end else if (w_handshake) begin
      if (w_last_col) begin
        r_col    <= '0;
        r_rd_sel <= ~r_rd_sel;
      end else begin
        r_col <= r_col + COLW'(1);
      end
    end
  end

  assign s_ready     = r_ready;
  assign err_len     = r_err;
  assign k_out_valid = w_out_valid;
  assign k_out_last  = w_out_valid & w_last_col;
  assign k_out_data  = w_out_valid ? w_col_data[r_rd_sel] : '0;

endmodule

// File: tb/tb_kernel_packer.sv
// Directed bench for kernel_packer; expected column order follows the
// KPACK_TRANSPOSE_EN setting of the build.
module tb_kernel_packer;
  import kpack_pkg::*;

  localparam int KD = DEF_K_DIM;
  localparam int MB = DEF_M_BITS;
  localparam int BW = KD * MB;

  logic                    clk;
  logic                    rst;
  logic [MB-1:0]           s_data;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;
  logic [KD-1:0][MB-1:0]   k_out_data;
  logic                    k_out_last;
  logic                    k_out_valid;
  logic                    k_out_ready;
  logic                    err_len;

  int checks;
  int errors;
  int errPulses;

  logic [15:0] fp [0:8];

  kernel_packer dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .k_out_data  (k_out_data),
    .k_out_last  (k_out_last),
    .k_out_valid (k_out_valid),
    .k_out_ready (k_out_ready),
    .err_len     (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with err_len high, sampled away from the active edge.
  always @(negedge clk) begin
    if (err_len === 1'b1) errPulses++;
  end

  // Expected column beat for kernel k holding n valid coefficients.
  function automatic logic [BW-1:0] expBeat(input logic [15:0] k [0:8], input int n, input int col);
    logic [BW-1:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < KD; j++) begin
`ifdef KPACK_TRANSPOSE_EN
      idx = j * KD + col;
`else
      idx = col * KD + j;
`endif
      if (idx < n) r[j*MB +: MB] = k[idx];
    end
    return r;
  endfunction

  // Stream n coefficients with valid held high; last on the final one if asked.
  task automatic send_kernel(input logic [15:0] k [0:8], input int n, input bit withLast, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int wait_n;
      wait_n  = 0;
      s_data  = k[i];
      s_last  = withLast && (i == n - 1);
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && wait_n < 300) begin
        @(posedge clk); #1;
        wait_n++;
      end
      if (s_ready !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Take one output beat, waiting a bounded time for valid.
  task automatic recv_beat(output logic [BW-1:0] d, output logic l, output bit ok);
    int wait_n;
    wait_n      = 0;
    k_out_ready = 1'b1;
    while (k_out_valid !== 1'b1 && wait_n < 300) begin
      @(posedge clk); #1;
      wait_n++;
    end
    ok = (k_out_valid === 1'b1);
    d  = k_out_data;
    l  = k_out_last;
    @(posedge clk); #1;
    k_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; k_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (k_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", k_out_valid); end
    checks++; if (k_out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b want 0", k_out_last); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err_len); end
    checks++; if (k_out_data !== '0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", k_out_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [BW-1:0] want [3];
    logic [BW-1:0] d;
    logic l;
    bit ok;
`ifdef KPACK_TRANSPOSE_EN
    want[0] = 48'h4700_4400_3C00;
    want[1] = 48'h4800_4500_4000;
    want[2] = 48'h4880_4600_4200;
`else
    want[0] = 48'h4200_4000_3C00;
    want[1] = 48'h4600_4500_4400;
    want[2] = 48'h4880_4800_4700;
`endif
    errPulses = 0;
    send_kernel(fp, 9, 1'b1, ok);
    checks++; if (!ok || k_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency got valid=%b ok=%0d want valid=1", k_out_valid, ok); end
    for (int c = 0; c < 3; c++) begin
      recv_beat(d, l, ok);
      checks++; if (!ok || d !== want[c]) begin errors++; $display("[TB] FAIL basic_col%0d got %h want %h", c, d, want[c]); end
      checks++; if (l !== (c == 2)) begin errors++; $display("[TB] FAIL basic_last%0d got %b want %b", c, l, (c == 2)); end
    end
    checks++; if (errPulses !== 0) begin errors++; $display("[TB] FAIL basic_err got %0d want 0", errPulses); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] kk [3][0:8];
    logic [BW-1:0] d;
    logic l;
    bit ok1, ok2, ok3;
    int badRx;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 9; i++) kk[k][i] = 16'(16'h1000 * (k + 1) + i);
    k_out_ready = 1'b0;
    send_kernel(kk[0], 9, 1'b1, ok1);
    send_kernel(kk[1], 9, 1'b1, ok2);
    checks++; if (!ok1 || !ok2 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall got s_ready=%b want 0", s_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (k_out_data !== expBeat(kk[0], 9, 0) || k_out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_hold got %h want %h", k_out_data, expBeat(kk[0], 9, 0)); end
    badRx = 0;
    fork
      send_kernel(kk[2], 9, 1'b1, ok3);
      begin
        for (int b = 0; b < 6; b++) begin
          bit okr;
          recv_beat(d, l, okr);
          checks++; if (!okr || d !== expBeat(kk[b / 3], 9, b % 3) || l !== (b % 3 == 2)) begin
            errors++; $display("[TB] FAIL b2b_beat%0d got %h last %b want %h", b, d, l, expBeat(kk[b / 3], 9, b % 3)); end
        end
      end
    join
    checks++; if (!ok3) begin errors++; $display("[TB] FAIL b2b_third_accept got 0 want 1"); end
    for (int c = 0; c < 3; c++) begin
      bit okr;
      recv_beat(d, l, okr);
      checks++; if (!okr || d !== expBeat(kk[2], 9, c)) begin errors++; $display("[TB] FAIL b2b_k3_col%0d got %h want %h", c, d, expBeat(kk[2], 9, c)); end
    end
  endtask

  task automatic test_short();
    logic [15:0] k2 [0:8];
    logic [BW-1:0] d;
    logic l;
    bit ok;
    for (int i = 0; i < 9; i++) k2[i] = 16'(16'h2100 + i);
    errPulses = 0;
    send_kernel(fp, 5, 1'b1, ok);
    for (int c = 0; c < 3; c++) begin
      bit okr;
      recv_beat(d, l, okr);
      checks++; if (!ok || !okr || d !== expBeat(fp, 5, c)) begin errors++; $display("[TB] FAIL short_col%0d got %h want %h", c, d, expBeat(fp, 5, c)); end
    end
    checks++; if (errPulses !== 1) begin errors++; $display("[TB] FAIL short_err got %0d want 1", errPulses); end
    send_kernel(k2, 9, 1'b1, ok);
    for (int c = 0; c < 3; c++) begin
      bit okr;
      recv_beat(d, l, okr);
      checks++; if (!ok || !okr || d !== expBeat(k2, 9, c)) begin errors++; $display("[TB] FAIL short_next_col%0d got %h want %h", c, d, expBeat(k2, 9, c)); end
    end
    checks++; if (errPulses !== 1) begin errors++; $display("[TB] FAIL short_next_err got %0d want 1", errPulses); end
  endtask

  task automatic test_missing_last();
    logic [15:0] k2 [0:8];
    logic [BW-1:0] d;
    logic l;
    bit ok1, ok2;
    for (int i = 0; i < 9; i++) k2[i] = 16'(16'h5000 + i);
    errPulses = 0;
    send_kernel(fp, 9, 1'b0, ok1);
    send_kernel(k2, 9, 1'b1, ok2);
    for (int b = 0; b < 6; b++) begin
      bit okr;
      logic [BW-1:0] want;
      want = (b < 3) ? expBeat(fp, 9, b) : expBeat(k2, 9, b - 3);
      recv_beat(d, l, okr);
      checks++; if (!ok1 || !ok2 || !okr || d !== want) begin errors++; $display("[TB] FAIL nolast_beat%0d got %h want %h", b, d, want); end
    end
    checks++; if (errPulses !== 1) begin errors++; $display("[TB] FAIL nolast_err got %0d want 1", errPulses); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] k2 [0:8];
    logic [BW-1:0] d;
    logic l;
    bit ok, okr;
    for (int i = 0; i < 9; i++) k2[i] = 16'(16'h6100 + 16'h11 * i);
    send_kernel(fp, 9, 1'b1, ok);
    recv_beat(d, l, okr);
    send_kernel(k2, 4, 1'b0, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (k_out_valid !== 1'b0 || k_out_last !== 1'b0 || k_out_data !== '0) begin
      errors++; $display("[TB] FAIL midrst_out got valid=%b last=%b data=%h want 0", k_out_valid, k_out_last, k_out_data); end
    checks++; if (s_ready !== 1'b1 || err_len !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_in got s_ready=%b err=%b want 1/0", s_ready, err_len); end
    @(posedge clk); #1;
    send_kernel(k2, 9, 1'b1, ok);
    for (int c = 0; c < 3; c++) begin
      recv_beat(d, l, okr);
      checks++; if (!ok || !okr || d !== expBeat(k2, 9, c) || l !== (c == 2)) begin
        errors++; $display("[TB] FAIL midrst_col%0d got %h last %b want %h", c, d, l, expBeat(k2, 9, c)); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (k_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drained got %b want 0", k_out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    errPulses = 0;
    fp[0] = 16'h3C00; fp[1] = 16'h4000; fp[2] = 16'h4200;
    fp[3] = 16'h4400; fp[4] = 16'h4500; fp[5] = 16'h4600;
    fp[6] = 16'h4700; fp[7] = 16'h4800; fp[8] = 16'h4880;
    $display("[TB] kernel_packer bench start");
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_missing_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
